// File: rtl/sseg_pkg.sv
// Shared types and segment constants for the seven-segment display driver.
// Segment bytes are active-low and ordered {dp,g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef logic [7:0] sseg_t;

  localparam sseg_t SEG_BLANK = 8'hFF;
  localparam sseg_t SEG_DASH  = 8'hBF;

  // Glyphs for BCD 0..9 with the dp bit left off (bit 7 = 1).
  localparam sseg_t SEG_DIGIT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to seven-segment decoder, active-low, no decimal point.
// Codes 10-15 are shown as a dash so a corrupted digit is visible.
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup for legal BCD, dash glyph for anything else.
  always_comb begin
    seg_o = SEG_DASH[6:0];
    if (bcd_i < 4'd10) begin
      seg_o = SEG_DIGIT[bcd_i][6:0];
    end
  end

endmodule

// File: rtl/sseg_disp_mux4.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A free-running counter picks the active digit (top two bits) and the PWM
// phase (next four bits); anode and segment outputs are registered together
// so a slot change never pairs a new anode with stale segments.
module sseg_disp_mux4
  import sseg_pkg::*;
#(
  parameter int unsigned N = 18
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] d3_i,
  input  logic [3:0] d2_i,
  input  logic [3:0] d1_i,
  input  logic [3:0] d0_i,
  input  logic [3:0] dp_en_i,
  input  logic       lzb_i,
  input  logic       blank_i,
  input  logic [3:0] bright_i,
  output logic [3:0] an_o,
  output sseg_t      sseg_o
);

  logic [N-1:0] q_q, q_d;
  logic [1:0]   sel;
  logic [3:0]   sub;
  logic [3:0]   digit;
  logic         lz_blank;
  logic         lit;
  logic [6:0]   seg7_dec;
  logic [6:0]   seg7;
  logic [3:0]   an_d;
  sseg_t        sseg_d;

  assign sel = q_q[N-1:N-2];
  assign sub = q_q[N-3:N-6];

  // Refresh counter: free-running, wraps naturally at 2**N.
  always_comb begin
    q_d = q_q + 1'b1;
  end

  // Active-digit mux and leading-zero test; non-BCD codes count as non-zero.
  always_comb begin
    digit    = d0_i;
    lz_blank = 1'b0;
    unique case (sel)
      2'd0: begin
        digit    = d0_i;
        lz_blank = 1'b0;
      end
      2'd1: begin
        digit    = d1_i;
        lz_blank = lzb_i && (d3_i == 4'd0) && (d2_i == 4'd0) && (d1_i == 4'd0);
      end
      2'd2: begin
        digit    = d2_i;
        lz_blank = lzb_i && (d3_i == 4'd0) && (d2_i == 4'd0);
      end
      2'd3: begin
        digit    = d3_i;
        lz_blank = lzb_i && (d3_i == 4'd0);
      end
      default: begin
        digit    = d0_i;
        lz_blank = 1'b0;
      end
    endcase
  end

  bcd_to_sseg u_dec (
    .bcd_i (digit),
    .seg_o (seg7_dec)
  );

  // Segment/anode next state: blank overrides duty, dp is independent of lzb.
  always_comb begin
    seg7   = lz_blank ? SEG_BLANK[6:0] : seg7_dec;
    sseg_d = {~dp_en_i[sel], seg7};
    lit    = (sub <= bright_i) && !blank_i;
    an_d   = lit ? ~(4'b0001 << sel) : 4'b1111;
  end

  // Counter and output registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      an_o   <= 4'b1111;
      sseg_o <= SEG_BLANK;
    end else begin
      q_q    <= q_d;
      an_o   <= an_d;
      sseg_o <= sseg_d;
    end
  end

endmodule

// File: tb/tb_sseg_disp_mux4.sv
// Scoreboard bench for sseg_disp_mux4 with N = 8 (64-cycle slots).
// The driver pushes the expected {an,sseg} for every cycle it issues; a
// monitor pops one entry per clock and compares against the DUT.
module tb_sseg_disp_mux4;

  localparam int unsigned N = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] d [4];
  logic [3:0] dp_en;
  logic       lzb;
  logic       blank;
  logic [3:0] bright;
  logic [3:0] an;
  logic [7:0] sseg;

  int total;
  int bad;
  int cnt;
  logic [11:0] exp_q [$];
  logic [7:0]  glyph [10];

  sseg_disp_mux4 #(.N(N)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .d3_i     (d[3]),
    .d2_i     (d[2]),
    .d1_i     (d[1]),
    .d0_i     (d[0]),
    .dp_en_i  (dp_en),
    .lzb_i    (lzb),
    .blank_i  (blank),
    .bright_i (bright),
    .an_o     (an),
    .sseg_o   (sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: slot = q/64, PWM phase = (q mod 64)/4, digit blanked when it
  // and every more significant digit are zero (digit 0 never).
  function automatic logic [11:0] model(input int qv);
    int         slot;
    int         ph;
    bit         all_zero;
    logic [7:0] s;
    logic [3:0] a;
    slot = qv / 64;
    ph   = (qv % 64) / 4;
    all_zero = 1'b1;
    for (int j = 3; j >= slot; j--) begin
      if (d[j] != 4'd0) all_zero = 1'b0;
    end
    if (lzb && slot != 0 && all_zero) s = 8'hFF;
    else if (d[slot] < 4'd10)         s = glyph[d[slot]];
    else                              s = 8'hBF;
    if (dp_en[slot]) s = s & 8'h7F;
    if (!blank && ph <= int'(bright)) a = ~(4'b0001 << slot);
    else                              a = 4'hF;
    return {a, s};
  endfunction

  // Issue one cycle: record what the next edge must produce, then advance.
  task automatic cyc();
    exp_q.push_back(model(cnt % 256));
    cnt++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_d(input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0);
    d[3] = a3; d[2] = a2; d[1] = a1; d[0] = a0;
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      bad++;
      $display("FAIL %s: an=%h sseg=%h, required an=F sseg=FF", tag, an, sseg);
    end
  endtask

  // Monitor: one expected entry per clock while the driver is issuing.
  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({an, sseg} !== e) begin
        bad++;
        $display("FAIL scan t=%0t: an=%h sseg=%h, required an=%h sseg=%h",
                 $time, an, sseg, e[11:8], e[7:0]);
      end
      total++;
      if (!(an inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF})) begin
        bad++;
        $display("FAIL onehot t=%0t: an=%h, required one-hot-low or F", $time, an);
      end
    end
  end

  initial begin
    glyph[0] = 8'hC0; glyph[1] = 8'hF9; glyph[2] = 8'hA4; glyph[3] = 8'hB0;
    glyph[4] = 8'h99; glyph[5] = 8'h92; glyph[6] = 8'h82; glyph[7] = 8'hF8;
    glyph[8] = 8'h80; glyph[9] = 8'h90;
    total = 0; bad = 0; cnt = 0;
    rst_n = 1'b0;
    set_d(4'd1, 4'd2, 4'd3, 4'd4);
    dp_en = 4'h0; lzb = 1'b0; blank = 1'b0; bright = 4'd15;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_initial");
    rst_n = 1'b1;
    cnt   = 0;

    // Plain scan with full brightness, then wrap past 2**N.
    run(256 + 10);
    run(246);

    // Leading-zero blanking with dp on a blanked digit.
    set_d(4'd0, 4'd0, 4'd7, 4'd0); lzb = 1'b1; dp_en = 4'b0100;
    run(256);

    // Dimming and full blank.
    set_d(4'd5, 4'd6, 4'd8, 4'd9); lzb = 1'b0; dp_en = 4'b0001;
    bright = 4'd3; run(256);
    bright = 4'd0; run(256);
    blank = 1'b1; bright = 4'd15; run(128);
    blank = 1'b0;

    // Invalid codes: dash glyph, and a non-BCD digit stops blanking.
    set_d(4'd1, 4'd2, 4'd3, 4'hC); dp_en = 4'h0; run(256);
    set_d(4'd0, 4'd0, 4'd0, 4'hA); lzb = 1'b1; run(256);

    // Reset in the middle of a slot, then restart from digit 0.
    run(100);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_midscan");
    repeat (5) @(negedge clk);
    check_reset_vals("reset_held");
    rst_n = 1'b1;
    cnt   = 0;
    set_d(4'd9, 4'd8, 4'd7, 4'd6); lzb = 1'b0; bright = 4'd15;
    run(200);

    // Random inputs every cycle, then held for longer stretches.
    for (int i = 0; i < 1600; i++) begin
      if (i < 1024 || (i % 37) == 0) begin
        for (int j = 0; j < 4; j++) begin
          d[j] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        dp_en  = 4'($urandom_range(0, 15));
        lzb    = 1'($urandom_range(0, 1));
        blank  = ($urandom_range(0, 7) == 0);
        bright = 4'($urandom_range(0, 15));
      end
      cyc();
    end

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
